// File: rtl/fixed_point_pkg.sv
// Shared types and constant helpers for the fixed-point add/sub datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fixed_point_pkg;

  // Status flags produced alongside every result.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } fxp_flags_t;

  // Width of one carry-chain segment; N must divide evenly by STAGES.
  function automatic int seg_w(input int n, input int stages);
    return n / stages;
  endfunction

  // Largest positive two's-complement value of width n (0x7F..F).
  function automatic logic [63:0] fxp_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width n (0x80..0).
  function automatic logic [63:0] fxp_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/fixed_point_addsub_pipe_cla.sv
// One combinational carry-lookahead segment of W bits: sum, carry-out, carry into the top bit.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when the outputs are captured.
module cla_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         term;
  logic         pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat lookahead sum-of-products over generate/propagate, not a ripple.
  always_comb begin
    c    = '0;
    term = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & cin);
    end
  end

  assign sum   = p ^ c[W-1:0];
  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Pipelined two's-complement add/sub; carry chain split into STAGES segments, one per stage.
// Latency: STAGES cycles (accepted at edge t, out_valid after edge t+STAGES-1).
// Backpressure: global stall; in_ready = !out_valid || out_ready, all stages hold when low.
// Optional: define FXP_ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module fixed_point_addsub_pipe
  import fixed_point_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         negative,
  output logic         zero
);
  localparam int           SEG_W    = seg_w(N, STAGES);
  localparam logic [N-1:0] SEG_ONES = {N{1'b1}} >> (N - SEG_W);

`ifdef FXP_ADDSUB_SATURATE_EN
  localparam logic [63:0]  MAX64   = fxp_max(N);
  localparam logic [63:0]  MIN64   = fxp_min(N);
  localparam logic [N-1:0] SAT_MAX = MAX64[N-1:0];
  localparam logic [N-1:0] SAT_MIN = MIN64[N-1:0];
`endif

  logic adv;

  // Stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
  logic [N-1:0]     a_src   [STAGES];
  logic [N-1:0]     b_src   [STAGES];
  logic [N-1:0]     s_src   [STAGES];
  logic             c_src   [STAGES];
  logic             v_src   [STAGES];

  // Per-stage combinational results.
  logic [SEG_W-1:0] seg_sum  [STAGES];
  logic             seg_cout [STAGES];
  logic             seg_cmsb [STAGES];
  logic [N-1:0]     s_new    [STAGES];

  // Per-stage registers: operand skew, partial result, segment carry, valid.
  logic [N-1:0]     a_q [STAGES];
  logic [N-1:0]     b_q [STAGES];
  logic [N-1:0]     s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  // Final-stage output registers.
  logic [N-1:0]     sum_fin;
  logic [N-1:0]     res_fin;
  logic [N-1:0]     res_q;
  fxp_flags_t       flags_fin;
  fxp_flags_t       flags_q;

  assign out_valid = v_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Subtract is folded in at entry: B is inverted and c0 forced to 1; cin is ignored.
  assign a_src[0] = a;
  assign b_src[0] = sub ? ~b : b;
  assign c_src[0] = sub ? 1'b1 : cin;
  assign s_src[0] = '0;
  assign v_src[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = v_q[k-1];
    end

    cla_segment #(.W(SEG_W)) u_seg (
      .a    (a_src[k][k*SEG_W +: SEG_W]),
      .b    (b_src[k][k*SEG_W +: SEG_W]),
      .cin  (c_src[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .c_msb(seg_cmsb[k])
    );

    // Drop this stage's finished segment into the partial result travelling with the op.
    assign s_new[k] = (s_src[k] & ~(SEG_ONES << (k*SEG_W)))
                    | (N'(seg_sum[k]) << (k*SEG_W));
  end

  assign sum_fin = s_new[STAGES-1];

  // Flags from the top segment; zero is taken on the value actually presented.
  always_comb begin
    flags_fin          = '0;
    flags_fin.carry    = seg_cout[STAGES-1];
    flags_fin.overflow = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    flags_fin.negative = flags_fin.overflow ^ sum_fin[N-1];
    res_fin            = sum_fin;
`ifdef FXP_ADDSUB_SATURATE_EN
    if (flags_fin.overflow) begin
      res_fin = flags_fin.negative ? SAT_MIN : SAT_MAX;
    end
`endif
    flags_fin.zero     = (res_fin == '0);
  end

  // All stages advance together on adv; reset flushes every in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      res_q   <= '0;
      flags_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_new[k];
        c_q[k] <= seg_cout[k];
        v_q[k] <= v_src[k];
      end
      res_q   <= res_fin;
      flags_q <= flags_fin;
    end
  end

  assign result   = res_q;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign negative = flags_q.negative;
  assign zero     = flags_q.zero;

endmodule
